// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: two-master (inst/data) arbiter onto one SRAM-like slave with in-order response routing
module sram_req_arbiter #(
  parameter int MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sl_req,
  output logic        sl_wr,
  output logic [1:0]  sl_size,
  output logic [31:0] sl_addr,
  output logic [31:0] sl_wdata,
  input  logic        sl_addr_ok,
  input  logic        sl_data_ok,
  input  logic [31:0] sl_rdata
);
  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;
  state_t               state_q, state_d;
  logic [MAX_OUTST-1:0] tags_q, tags_d;
  logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 full_q, full_d;
  logic                 err_underflow, err_underflow_d;
  logic                 grant_i, grant_d, accept, pop, head;
  // Grant: fixed data priority in IDLE, sticky in HOLD_x, nothing while full or in reset
  always_comb begin
    grant_i = resetn && !full_q && (state_q == HOLD_I ? inst_req : state_q == IDLE && inst_req && !data_req);
    grant_d = resetn && !full_q && (state_q == HOLD_D ? data_req : state_q == IDLE && data_req);
    accept = (grant_i || grant_d) && sl_addr_ok;
    head = tags_q[rptr_q];
    pop = sl_data_ok && cnt_q != '0;
  end
  // Slave-side mux and master-side handshake/response routing
  always_comb begin
    sl_req = grant_i || grant_d;
    sl_wr = grant_d ? data_wr : grant_i && inst_wr;
    sl_size = grant_d ? data_size : grant_i ? inst_size : 2'b0;
    sl_addr = grant_d ? data_addr : grant_i ? inst_addr : 32'h0;
    sl_wdata = grant_d ? data_wdata : grant_i ? inst_wdata : 32'h0;
    inst_addr_ok = grant_i && sl_addr_ok;
    data_addr_ok = grant_d && sl_addr_ok;
    inst_data_ok = pop && !head;
    data_data_ok = pop && head;
    inst_rdata = resetn ? sl_rdata : 32'h0;
    data_rdata = resetn ? sl_rdata : 32'h0;
  end
  // Next-state: FSM, tag FIFO pointers/occupancy and sticky underflow flag
  always_comb begin
    state_d = full_q ? state_q : (sl_req && !sl_addr_ok) ? (grant_d ? HOLD_D : HOLD_I) : IDLE;
    tags_d = tags_q;
    if (accept) tags_d[wptr_q] = grant_d;
    wptr_d = accept ? wptr_q + PW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + PW'(1) : rptr_q;
    cnt_d = cnt_q + CW'(accept) - CW'(pop);
    full_d = cnt_d == CW'(MAX_OUTST);
    err_underflow_d = err_underflow || (sl_data_ok && cnt_q == '0);
  end
  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      tags_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      full_q <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state_q <= state_d;
      tags_q <= tags_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      full_q <= full_d;
      err_underflow <= err_underflow_d;
    end
  end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb_sram_req_arbiter: scoreboard bench for sram_req_arbiter (tag order, handshake, reset, underflow)
module tb_sram_req_arbiter;
  localparam logic [31:0] IADDR = 32'h1000_0040;
  localparam logic [31:0] DADDR = 32'h2000_0080;
  logic        clk, resetn;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        sl_req, sl_wr, sl_addr_ok, sl_data_ok;
  logic [1:0]  sl_size;
  logic [31:0] sl_addr, sl_wdata, sl_rdata;
  int errors = 0;
  int checks = 0;
  bit exp_q[$];

  sram_req_arbiter #(.MAX_OUTST(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sl_req(sl_req), .sl_wr(sl_wr), .sl_size(sl_size), .sl_addr(sl_addr), .sl_wdata(sl_wdata),
    .sl_addr_ok(sl_addr_ok), .sl_data_ok(sl_data_ok), .sl_rdata(sl_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge and drop all pulse inputs
  task automatic cyc();
    @(posedge clk);
    #1;
    inst_req = 0; data_req = 0; sl_addr_ok = 0; sl_data_ok = 0; sl_rdata = '0;
  endtask

  // drive a slave response, settle, and compare routing against the scoreboard head
  task automatic resp(input logic [31:0] rd);
    bit t;
    sl_data_ok = 1; sl_rdata = rd;
    #2;
    check("sb_nonempty", 32'(exp_q.size() != 0), 1);
    t = exp_q.size() != 0 ? exp_q.pop_front() : 1'b0;
    check("inst_data_ok", inst_data_ok, !t);
    check("data_data_ok", data_data_ok, t);
    check("inst_rdata", inst_rdata, rd);
    check("data_rdata", data_rdata, rd);
  endtask

  initial begin
    bit pi, pd, gi, gd, full;
    int ms, acc;
    inst_addr = IADDR; inst_wdata = 32'hAAAA_0001; inst_size = 2'd2; inst_wr = 0;
    data_addr = DADDR; data_wdata = 32'hBBBB_0002; data_size = 2'd1; data_wr = 1;
    resetn = 0; inst_req = 0; data_req = 1; sl_addr_ok = 1; sl_data_ok = 1; sl_rdata = 32'hDEAD_BEEF;
    #3;
    check("rst_sl_req", sl_req, 0);
    check("rst_d_aok", data_addr_ok, 0);
    check("rst_d_dok", data_data_ok, 0);
    check("rst_rdata", data_rdata, 0);
    check("rst_sl_addr", sl_addr, 0);
    check("rst_cnt", dut.cnt_q, 0);
    cyc(); resetn = 1;
    // simultaneous requests: data wins, inst follows
    cyc(); inst_req = 1; data_req = 1; sl_addr_ok = 1; #2;
    check("pri_d_aok", data_addr_ok, 1);
    check("pri_i_aok", inst_addr_ok, 0);
    check("pri_sl_addr", sl_addr, DADDR);
    check("pri_sl_wr", sl_wr, 1);
    check("pri_sl_size", sl_size, 1);
    exp_q.push_back(1);
    cyc(); inst_req = 1; sl_addr_ok = 1; #2;
    check("pri2_i_aok", inst_addr_ok, 1);
    check("pri2_sl_addr", sl_addr, IADDR);
    check("pri2_sl_wdata", sl_wdata, 32'hAAAA_0001);
    exp_q.push_back(0);
    cyc(); resp(32'h11);
    check("full_cnt", dut.cnt_q, 2);
    cyc(); resp(32'h22);
    cyc(); #2;
    check("drain_cnt", dut.cnt_q, 0);
    // inst held in HOLD_I while data arrives
    cyc(); inst_req = 1; #2;
    check("hold_sl_addr0", sl_addr, IADDR);
    cyc(); inst_req = 1; data_req = 1; #2;
    check("hold_sl_addr1", sl_addr, IADDR);
    check("hold_d_aok1", data_addr_ok, 0);
    cyc(); inst_req = 1; data_req = 1; sl_addr_ok = 1; #2;
    check("hold_sl_addr2", sl_addr, IADDR);
    check("hold_i_aok", inst_addr_ok, 1);
    check("hold_d_aok2", data_addr_ok, 0);
    exp_q.push_back(0);
    cyc(); data_req = 1; sl_addr_ok = 1; #2;
    check("after_d_aok", data_addr_ok, 1);
    check("after_sl_addr", sl_addr, DADDR);
    exp_q.push_back(1);
    // full: third request blocked
    cyc(); inst_req = 1; sl_addr_ok = 1; #2;
    check("full_sl_req", sl_req, 0);
    check("full_i_aok", inst_addr_ok, 0);
    cyc(); inst_req = 1; sl_addr_ok = 1; resp(32'h1234_5678);
    check("full_pop_sl_req", sl_req, 0);
    // push and pop in the same cycle keep occupancy
    cyc(); inst_req = 1; sl_addr_ok = 1; resp(32'h33);
    check("pp_i_aok", inst_addr_ok, 1);
    exp_q.push_back(0);
    cyc(); #2;
    check("pp_cnt", dut.cnt_q, 1);
    cyc(); resp(32'h44);
    // random back-to-back traffic against a small arbitration model
    pi = 0; pd = 0; ms = 0; acc = 0;
    for (int c = 0; c < 200 && acc < 8; c++) begin
      cyc();
      if (!pi) pi = 1'($urandom_range(0, 1));
      if (!pd) pd = 1'($urandom_range(0, 1));
      inst_req = pi; data_req = pd; sl_addr_ok = 1'($urandom_range(0, 1));
      full = exp_q.size() == 2;
      gi = !full && (ms == 1 ? pi : ms == 0 && pi && !pd);
      gd = !full && (ms == 2 ? pd : ms == 0 && pd);
      if (exp_q.size() != 0 && $urandom_range(0, 1) == 1) resp(32'(c) | 32'hC000_0000);
      else #2;
      check("rnd_i_aok", inst_addr_ok, gi && sl_addr_ok);
      check("rnd_d_aok", data_addr_ok, gd && sl_addr_ok);
      check("rnd_sl_req", sl_req, gi || gd);
      if ((gi || gd) && sl_addr_ok) begin
        exp_q.push_back(gd);
        acc++;
        if (gd) pd = 0; else pi = 0;
        ms = 0;
      end else if (!full) ms = gd ? 2 : gi ? 1 : 0;
    end
    check("rnd_accepted", acc, 8);
    for (int k = 0; k < 4 && exp_q.size() != 0; k++) begin
      cyc(); resp(32'h5000 + 32'(k));
    end
    cyc(); #2;
    check("rnd_cnt", dut.cnt_q, 0);
    // HOLD_D cancelled: back to IDLE, no push, later underflow
    cyc(); data_req = 1; #2;
    check("cx_sl_addr", sl_addr, DADDR);
    cyc(); inst_req = 1; sl_addr_ok = 1; #2;
    check("cx_sl_req", sl_req, 0);
    check("cx_i_aok", inst_addr_ok, 0);
    cyc(); inst_req = 1; #2;
    check("cx_idle_grant", sl_addr, IADDR);
    check("cx_cnt", dut.cnt_q, 0);
    cyc();
    cyc(); sl_data_ok = 1; sl_rdata = 32'h55; #2;
    check("uf_i_dok", inst_data_ok, 0);
    check("uf_d_dok", data_data_ok, 0);
    cyc(); #2;
    check("uf_err", dut.err_underflow, 1);
    check("uf_cnt", dut.cnt_q, 0);
    // asynchronous reset with two outstanding
    cyc(); inst_req = 1; sl_addr_ok = 1;
    cyc(); data_req = 1; sl_addr_ok = 1;
    cyc(); data_req = 1; sl_addr_ok = 1; sl_data_ok = 1; sl_rdata = 32'h77; #2;
    check("pre_rst_i_dok", inst_data_ok, 1);
    resetn = 0; #1;
    check("arst_i_dok", inst_data_ok, 0);
    check("arst_rdata", inst_rdata, 0);
    check("arst_d_aok", data_addr_ok, 0);
    check("arst_cnt", dut.cnt_q, 0);
    check("arst_err", dut.err_underflow, 0);
    cyc(); resetn = 1;
    exp_q.delete();
    #2;
    check("rel_cnt", dut.cnt_q, 0);
    cyc(); sl_data_ok = 1; sl_rdata = 32'h88; #2;
    check("rel_i_dok", inst_data_ok, 0);
    check("rel_d_dok", data_data_ok, 0);
    cyc(); #2;
    check("rel_err", dut.err_underflow, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
